// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and reset constants for the reg_file_param block.
//   rf_state_t     : clear-sequencer FSM state (IDLE, CLEAR)
//   DATA_RST_BIT   : reset value replicated across every data bit
//   VALID_RST      : reset value of every per-word valid bit
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  localparam logic DATA_RST_BIT = 1'b0;
  localparam logic VALID_RST    = 1'b0;

endpackage

// File: rtl/reg_file_param_word.sv
// reg_word: one WIDTH-bit storage word plus its valid bit.
//   clk      in   falling-edge clock
//   clr_n    in   asynchronous active-low reset
//   clr_i    in   synchronous clear of data and valid (highest priority)
//   we_i     in   load wdata_i and set valid
//   wdata_i  in   write data
//   data_o   out  stored word
//   valid_o  out  stored valid bit
module reg_word
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Priority: clear, then write, then hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = {WIDTH{DATA_RST_BIT}};
      valid_d = VALID_RST;
    end else if (we_i) begin
      data_d  = wdata_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q  <= {WIDTH{DATA_RST_BIT}};
      valid_q <= VALID_RST;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, one write port, two registered
// read ports with write-to-read bypass, per-word valid bits and a sequenced
// bulk-clear engine. Every state element updates on the falling clock edge.
//   clk, clr_n          falling-edge clock, async active-low reset
//   we/waddr/wdata      write port (dropped while busy)
//   raddr_a/raddr_b     read addresses; rdata_x/rvalid_x one edge later
//   clear_req, busy     start a clear; busy covers the DEPTH clearing edges
//   dbg_state, dbg_ptr  clear FSM state (1 = CLEAR) and clear pointer
//
// Protocol: clear_req is a level sampled only at edges where busy is low;
// a sampled request raises busy at that same edge, and busy stays high for
// exactly DEPTH edges. Requests and writes seen while busy is high are
// ignored, not queued.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  input  logic              clear_req,
  output logic              busy,
  output logic              dbg_state,
  output logic [ADDR_W-1:0] dbg_ptr
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0]  rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;

  logic [WIDTH-1:0]  word_data [DEPTH];
  logic [DEPTH-1:0]  word_valid;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  clr_sel;
  logic              wr_acc;

  // busy_q mirrors state_q, so gating on it is the same as "state is IDLE".
  assign wr_acc = we && !busy_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign wr_sel[i]  = wr_acc && (waddr == ADDR_W'(i));
    assign clr_sel[i] = (state_q == CLEAR) && (ptr_q == ADDR_W'(i));

    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk     (clk),
      .clr_n   (clr_n),
      .clr_i   (clr_sel[i]),
      .we_i    (wr_sel[i]),
      .wdata_i (wdata),
      .data_o  (word_data[i]),
      .valid_o (word_valid[i])
    );
  end

  // Read muxes: array contents are pre-edge values; an accepted write to the
  // same address overrides them so the port sees the new data one edge later.
  always_comb begin
    rdata_a_d  = word_data[raddr_a];
    rvalid_a_d = word_valid[raddr_a];
    rdata_b_d  = word_data[raddr_b];
    rvalid_b_d = word_valid[raddr_b];
    if (wr_acc && (waddr == raddr_a)) begin
      rdata_a_d  = wdata;
      rvalid_a_d = 1'b1;
    end
    if (wr_acc && (waddr == raddr_b)) begin
      rdata_b_d  = wdata;
      rvalid_b_d = 1'b1;
    end
  end

  // Clear FSM: one word per edge, leaving after the last word with the
  // pointer wrapped back to zero.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      rdata_a_q  <= {WIDTH{DATA_RST_BIT}};
      rdata_b_q  <= {WIDTH{DATA_RST_BIT}};
      rvalid_a_q <= VALID_RST;
      rvalid_b_q <= VALID_RST;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign busy      = busy_q;
  assign dbg_state = (state_q == CLEAR);
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 4x4 instance plus an 8x16 one.
module tb_reg_file_param;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr_n;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- default instance (WIDTH=4, DEPTH=4) ----------------
  logic       we, clear_req;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [3:0] wdata;
  logic [3:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b, busy, dbg_state;
  logic [1:0] dbg_ptr;

  reg_file_param u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .clear_req (clear_req),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- wide instance (WIDTH=8, DEPTH=16) ----------------
  logic       b_we, b_clear_req;
  logic [3:0] b_waddr, b_raddr_a, b_raddr_b;
  logic [7:0] b_wdata;
  logic [7:0] b_rdata_a, b_rdata_b;
  logic       b_rvalid_a, b_rvalid_b, b_busy, b_dbg_state;
  logic [3:0] b_dbg_ptr;

  reg_file_param #(
    .WIDTH (8),
    .DEPTH (16)
  ) u_dut_w (
    .clk       (clk),
    .clr_n     (clr_n),
    .we        (b_we),
    .waddr     (b_waddr),
    .wdata     (b_wdata),
    .raddr_a   (b_raddr_a),
    .raddr_b   (b_raddr_b),
    .rdata_a   (b_rdata_a),
    .rdata_b   (b_rdata_b),
    .rvalid_a  (b_rvalid_a),
    .rvalid_b  (b_rvalid_b),
    .clear_req (b_clear_req),
    .busy      (b_busy),
    .dbg_state (b_dbg_state),
    .dbg_ptr   (b_dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance past the active (falling) edge and settle before sampling/driving.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int cnt;
  bit done;

  initial begin
    clr_n = 1'b0;
    we = 1'b0; clear_req = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    b_we = 1'b0; b_clear_req = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr_a = '0; b_raddr_b = '0;

    // Reset state
    #2;
    check("rst_rdata_a", 32'(rdata_a), 32'h0);
    check("rst_rvalid_a", 32'(rvalid_a), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    #10 clr_n = 1'b1;

    // Write/read
    wr(2'd2, 4'hA);
    wr(2'd3, 4'h5);
    raddr_a = 2'd2; raddr_b = 2'd3;
    tick();
    check("rd_a_w2", 32'(rdata_a), 32'hA);
    check("rv_a_w2", 32'(rvalid_a), 32'h1);
    check("rd_b_w3", 32'(rdata_b), 32'h5);
    check("rv_b_w3", 32'(rvalid_b), 32'h1);
    raddr_a = 2'd0;
    tick();
    check("rd_a_w0_empty", 32'(rdata_a), 32'h0);
    check("rv_a_w0_empty", 32'(rvalid_a), 32'h0);

    // Bypass: write word 1 while port A reads it on the same edge
    raddr_a = 2'd1;
    wr(2'd1, 4'hC);
    check("byp_rd_a", 32'(rdata_a), 32'hC);
    check("byp_rv_a", 32'(rvalid_a), 32'h1);
    wr(2'd0, 4'h3);  // all four words now 3,C,A,5

    // Clear sequence
    raddr_a = 2'd0; raddr_b = 2'd3;
    clear_req = 1'b1;
    tick();  // E0: request sampled
    clear_req = 1'b0;
    check("clr_e0_busy", 32'(busy), 32'h1);
    check("clr_e0_rd_a", 32'(rdata_a), 32'h3);
    we = 1'b1; waddr = 2'd2; wdata = 4'hF;  // must be dropped
    tick();  // E1: word 0 cleared, read returns old value
    we = 1'b0;
    check("clr_e1_busy", 32'(busy), 32'h1);
    check("clr_e1_old_w0", 32'(rdata_a), 32'h3);
    check("clr_e1_old_v0", 32'(rvalid_a), 32'h1);
    raddr_b = 2'd2;
    clear_req = 1'b1;  // ignored while clearing
    tick();  // E2: word 1 cleared
    clear_req = 1'b0;
    check("clr_e2_busy", 32'(busy), 32'h1);
    check("clr_e2_w0_zero", 32'(rdata_a), 32'h0);
    check("clr_e2_w0_inval", 32'(rvalid_a), 32'h0);
    check("clr_e2_w2_drop", 32'(rdata_b), 32'hA);
    tick();  // E3: word 2 cleared
    check("clr_e3_busy", 32'(busy), 32'h1);
    tick();  // E4: word 3 cleared, busy falls
    check("clr_e4_busy", 32'(busy), 32'h0);
    check("clr_e4_state", 32'(dbg_state), 32'h0);
    check("clr_e4_ptr", 32'(dbg_ptr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i);
      raddr_b = 2'(3 - i);
      tick();
      check("post_clr_rv_a", 32'(rvalid_a), 32'h0);
      check("post_clr_rv_b", 32'(rvalid_b), 32'h0);
      check("post_clr_rd_a", 32'(rdata_a), 32'h0);
    end
    check("post_clr_busy", 32'(busy), 32'h0);

    // Write and clear_req on the same edge
    raddr_a = 2'd2;
    we = 1'b1; waddr = 2'd2; wdata = 4'h9; clear_req = 1'b1;
    tick();  // E0: write done, clear starts
    we = 1'b0; clear_req = 1'b0;
    check("sim_byp_rd", 32'(rdata_a), 32'h9);
    check("sim_busy", 32'(busy), 32'h1);
    tick();  // E1
    check("sim_e1_rd", 32'(rdata_a), 32'h9);
    tick();  // E2
    tick();  // E3: word 2 cleared now, old value read
    check("sim_e3_rd_old", 32'(rdata_a), 32'h9);
    tick();  // E4
    check("sim_e4_rd", 32'(rdata_a), 32'h0);
    check("sim_e4_rv", 32'(rvalid_a), 32'h0);
    check("sim_e4_busy", 32'(busy), 32'h0);

    // Reset in the middle of a clear
    raddr_a = 2'd1;
    wr(2'd1, 4'h7);
    clear_req = 1'b1;
    tick();  // E0
    clear_req = 1'b0;
    tick();  // E1
    check("pre_rst_rd_a", 32'(rdata_a), 32'h7);
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_rd_a", 32'(rdata_a), 32'h0);
    check("mid_rst_rv_a", 32'(rvalid_a), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_ptr", 32'(dbg_ptr), 32'h0);
    #2 clr_n = 1'b1;
    tick();
    check("post_rst_w1_rd", 32'(rdata_a), 32'h0);
    check("post_rst_w1_rv", 32'(rvalid_a), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Wide instance: WIDTH=8, DEPTH=16
    b_we = 1'b1; b_waddr = 4'd15; b_wdata = 8'hFF;
    tick();
    b_we = 1'b0;
    b_raddr_a = 4'd15; b_raddr_b = 4'd15;
    tick();
    check("w_rd_a15", 32'(b_rdata_a), 32'hFF);
    check("w_rd_b15", 32'(b_rdata_b), 32'hFF);
    check("w_rv_a15", 32'(b_rvalid_a), 32'h1);
    b_clear_req = 1'b1;
    tick();  // E0
    b_clear_req = 1'b0;
    cnt = b_busy ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        tick();
        if (b_busy) cnt++;
        else done = 1'b1;
      end
    end
    check("w_clr_done", 32'(done), 32'h1);
    check("w_busy_edges", 32'(cnt), 32'd16);
    check("w_ptr_wrap", 32'(b_dbg_ptr), 32'h0);
    tick();
    check("w_rd_a15_clr", 32'(b_rdata_a), 32'h0);
    check("w_rv_b15_clr", 32'(b_rvalid_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-port register file, the successor to the fixed 4-word × 4-bit register bank. It provides:

- `DEPTH` words of `WIDTH` bits.
- One write port and two independent registered read ports, with write-to-read bypass.
- Per-word valid bits.
- A sequenced bulk-clear engine.

It sits between datapath sources and the display/ALU consumers, replacing the single-mux read path.

## Interface

- `WIDTH`, 4, data bits per word (≥1)
- `DEPTH`, 4, number of words (power of two, ≥2)
- `ADDR_W`, $clog2(DEPTH), address width (derived; do not override)

Ports:

- `clk`  in  1  clock; all state changes on the falling edge
- `clr_n`  in  1  reset, asynchronous, active-low
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `wdata`  in  WIDTH  write data
- `raddr_a`  in  ADDR_W  read address, port A
- `raddr_b`  in  ADDR_W  read address, port B
- `rdata_a`  out  WIDTH  registered read data, port A
- `rdata_b`  out  WIDTH  registered read data, port B
- `rvalid_a`  out  1  valid bit of word read on A
- `rvalid_b`  out  1  valid bit of word read on B
- `clear_req`  in  1  start sequenced clear of all words
- `busy`  out  1  clear sequence in progress

## Operation

- **Reset** (`clr_n`=0, immediate, independent of `clk`):
  - All words cleared to 0 and all valid bits cleared to 0.
  - `rdata_a`, `rdata_b`, `rvalid_a`, `rvalid_b` and `busy` are 0.
  - FSM state is IDLE and the clear pointer is 0.
  - Reset mid-clear aborts the sequence.
- **Write:** accepted when `we`=1 and state is IDLE.
  - `word[waddr]` <= `wdata` and `valid[waddr]` <= 1.
  - A write while `busy`=1 is silently dropped.
- **Read** (each port independent): at every falling edge:
  - `rdata_x` <= `word[raddr_x]` and `rvalid_x` <= `valid[raddr_x]`, taken from pre-edge contents.
  - **Bypass:** if a write is accepted on the same edge and `waddr`==`raddr_x`, then `rdata_x` <= `wdata` and `rvalid_x` <= 1.
  - Both ports may address the same word; both return identical data.
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE -> CLEAR when `clear_req`=1 at an edge; the pointer is loaded with 0.
  - In CLEAR, each edge does `word[ptr]` <= 0, `valid[ptr]` <= 0, `ptr` <= `ptr`+1.
  - CLEAR -> IDLE on the edge that clears `ptr`==DEPTH-1; the pointer wraps to 0.
  - `clear_req` is ignored while in CLEAR (no restart, no queueing).
- **Simultaneous write and `clear_req` in IDLE:** the write is performed, and the clear starts at the same edge, so the written word is cleared later in the sequence.
- **Reads during CLEAR:** allowed. A word cleared on an earlier edge reads 0 with valid 0. A read of the word being cleared on the current edge returns its old value.

## Timing

- Falling-edge triggered throughout; there is no rising-edge logic.
- Read latency is 1 edge from address to `rdata`/`rvalid`, including the bypass path.
- Write latency is 1 edge: data is visible through the array to a read issued on the next edge.
- `busy` is a registered decode of state. It rises at the edge that samples `clear_req`, stays high exactly DEPTH edges, and falls at the edge that clears the last word.
- The first write accepted after a clear is the one presented on the edge at which `busy` falls? No: `we` is sampled at an edge where the pre-edge state is IDLE, which is the edge after `busy` falls.
- All outputs are glitch-free registers. No combinational path runs from inputs to outputs.

## Structure

- Package `reg_file_pkg`:
  - FSM state enum `rf_state_t` {IDLE, CLEAR}.
  - Reset constants for data and valid (all zeros).
- Sub-module `reg_word`: one `WIDTH`-bit word plus its valid bit.
  - Async active-low reset; falling-edge clock.
  - Priority inputs: clear over write enable over hold.
  - Instantiated DEPTH times with a generate loop.
- The top level holds:
  - Write decoder (one-hot, gated with `we` and `!busy`).
  - Clear decoder (one-hot from `ptr`, gated with CLEAR).
  - Two read muxes with bypass comparators.
  - Output registers and the FSM.

## Test plan

- **Reset:** pulse `clr_n` low mid-cycle with prior contents -> all outputs 0 immediately; after release, reading any address gives `rdata` 0, `rvalid` 0.
- **Write/read (defaults):** write word 2 = 0xA, word 3 = 0x5; read A=2, B=3 -> `rdata_a`=0xA, `rdata_b`=0x5, both valid 1 one edge later. Word 0 reads 0, valid 0.
- **Bypass:** write word 1 = 0xC while `raddr_a`=1 on the same edge -> `rdata_a`=0xC, `rvalid_a`=1 after that edge, despite the old value 0.
- **Clear sequence:** fill all 4 words, assert `clear_req` for 1 cycle -> `busy` high exactly 4 edges; reads track word-by-word zeroing; a write attempted during `busy` is dropped; `rvalid` is 0 everywhere afterwards.
- **Simultaneous events:** write plus `clear_req` on the same edge -> written word is cleared within the sequence. `clear_req` during CLEAR -> no extension of `busy`. `clr_n` low on edge 2 of clear -> FSM IDLE and all words 0.
- **Parameter sweep:** WIDTH=8, DEPTH=16 -> write 0xFF to word 15, read on both ports gives 0xFF; clear takes 16 edges and the pointer wraps to 0.
